// File: rtl/game_pkg.sv
// Shared game-mode encoding and BCD limits for the scoring path.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      PLAY   = 3'b010,
      PAUSE  = 3'b011,
      FINISH = 3'b101
   } mode_t;

   localparam logic [7:0] BCD_MAX = 8'h99;

   // Unused encodings from the game FSM collapse to IDLE.
   function automatic mode_t decode_mode(input logic [2:0] m);
      case (m)
         3'b010:  return PLAY;
         3'b011:  return PAUSE;
         3'b101:  return FINISH;
         default: return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational 2-digit BCD add of a small addend, saturating at 99.
// Zero latency; no handshake.
module bcd_add_sat
   import game_pkg::*;
(
   input  logic [7:0] bcd_in,
   input  logic [1:0] addend,
   output logic [7:0] sum
);

   logic [4:0] ones_raw;
   logic [4:0] tens_raw;
   logic [3:0] ones_fix;
   logic       carry;

   always_comb begin
      ones_raw = {1'b0, bcd_in[3:0]} + {3'b000, addend};
      carry    = (ones_raw > 5'd9);
      ones_fix = carry ? 4'(ones_raw - 5'd10) : ones_raw[3:0];
      tens_raw = {1'b0, bcd_in[7:4]} + {4'b0000, carry};
      sum      = (tens_raw > 5'd9) ? BCD_MAX : {tens_raw[3:0], ones_fix};
   end

endmodule

// File: rtl/score_keeper.sv
// Saturating BCD score with hit-streak multiplier; 1-cycle update, strobes never stalled.
// Optional MISS_PENALTY_EN: an accepted miss also takes one point off the score (floor 00).
module score_keeper
   import game_pkg::*;
#(
   parameter int COMBO_STEP = 4,
   parameter int MAX_MULT   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mode,
   input  logic       hit,
   input  logic       miss,
   output logic [7:0] score,
   output logic [1:0] mult,
   output logic       game_over
);

   localparam int              CNT_W    = $clog2(COMBO_STEP + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMBO_STEP - 1);
   localparam logic [1:0]      MULT_TOP = 2'(MAX_MULT);

   mode_t            cur_mode;
   mode_t            prev_mode;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [7:0]       score_nxt;
   logic [7:0]       add_sum;
   logic [1:0]       mult_nxt;
   logic             new_game;
   logic             go_nxt;

   bcd_add_sat u_add (
      .bcd_in (score),
      .addend (mult),
      .sum    (add_sum)
   );

   always_comb begin
      cur_mode  = decode_mode(mode);
      new_game  = (cur_mode == PLAY) && (prev_mode != PLAY) && (prev_mode != PAUSE);
      go_nxt    = (cur_mode == FINISH) && (prev_mode != FINISH);
      score_nxt = score;
      mult_nxt  = mult;
      cnt_nxt   = cnt;

      if (new_game) begin
         score_nxt = 8'h00;
         mult_nxt  = 2'd1;
         cnt_nxt   = '0;
      end else if (cur_mode == PLAY) begin
         // Miss dominates a simultaneous hit.
         if (miss) begin
            mult_nxt = 2'd1;
            cnt_nxt  = '0;
`ifdef MISS_PENALTY_EN
            if (score != 8'h00) begin
               if (score[3:0] == 4'd0)
                  score_nxt = {score[7:4] - 4'd1, 4'd9};
               else
                  score_nxt = {score[7:4], score[3:0] - 4'd1};
            end
`endif
         end else if (hit) begin
            score_nxt = add_sum;
            if (mult < MULT_TOP) begin
               if (cnt == CNT_LAST) begin
                  mult_nxt = mult + 2'd1;
                  cnt_nxt  = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         score     <= 8'h00;
         mult      <= 2'd1;
         cnt       <= '0;
         game_over <= 1'b0;
         prev_mode <= IDLE;
      end else begin
         score     <= score_nxt;
         mult      <= mult_nxt;
         cnt       <= cnt_nxt;
         game_over <= go_nxt;
         prev_mode <= cur_mode;
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed scenarios plus random play against an integer model.
module tb_score_keeper;

   localparam int STEP  = 4;
   localparam int MAXM  = 3;
   localparam int M_IDLE = 0, M_PLAY = 2, M_PAUSE = 3, M_FIN = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] mode;
   logic       hit;
   logic       miss;
   logic [7:0] score;
   logic [1:0] mult;
   logic       game_over;

   score_keeper #(.COMBO_STEP(STEP), .MAX_MULT(MAXM)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .hit       (hit),
      .miss      (miss),
      .score     (score),
      .mult      (mult),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] score;
      logic [1:0] mult;
      logic       go;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: plain integers, score held as 0..99.
   int m_score, m_mult, m_cnt, m_pm;
   bit m_go;

   function automatic int dec(input logic [2:0] m);
      case (m)
         3'b010:  return M_PLAY;
         3'b011:  return M_PAUSE;
         3'b101:  return M_FIN;
         default: return M_IDLE;
      endcase
   endfunction

   function automatic logic [7:0] to_bcd(input int s);
      return 8'((s / 10) * 16 + (s % 10));
   endfunction

   task automatic model_reset();
      m_score = 0; m_mult = 1; m_cnt = 0; m_pm = M_IDLE; m_go = 0;
   endtask

   task automatic model_step(input bit r, input logic [2:0] md, input bit h, input bit m);
      int cur;
      if (r) begin
         model_reset();
         return;
      end
      cur  = dec(md);
      m_go = (cur == M_FIN) && (m_pm != M_FIN);
      if (cur == M_PLAY && m_pm != M_PLAY && m_pm != M_PAUSE) begin
         m_score = 0; m_mult = 1; m_cnt = 0;
      end else if (cur == M_PLAY) begin
         if (m) begin
            m_mult = 1; m_cnt = 0;
`ifdef MISS_PENALTY_EN
            if (m_score > 0) m_score = m_score - 1;
`endif
         end else if (h) begin
            m_score = (m_score + m_mult > 99) ? 99 : m_score + m_mult;
            if (m_mult < MAXM) begin
               m_cnt++;
               if (m_cnt == STEP) begin
                  m_mult++; m_cnt = 0;
               end
            end
         end
      end
      m_pm = cur;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input bit r, input logic [2:0] md, input bit h, input bit m);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; mode = md; hit = h; miss = m;
      model_step(r, md, h, m);
      e.cyc = cyc + 1; e.score = to_bcd(m_score); e.mult = 2'(m_mult); e.go = m_go;
      exp_q.push_back(e);
   endtask

   // Assert reset between edges and check the outputs clear without waiting for a clock.
   task automatic async_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_score", int'(score), 0);
      chk("async_rst_mult", int'(mult), 1);
      chk("async_rst_go", int'(game_over), 0);
      exp_q.delete();
      model_reset();
      step(1'b1, mode, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are live every cycle, compared mid-cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
               chk("stale_expectation", e.cyc, cyc);
            end else begin
               chk("score", int'(score), int'(e.score));
               chk("mult", int'(mult), int'(e.mult));
               chk("game_over", int'(game_over), int'(e.go));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; mode = 3'b000; hit = 1'b0; miss = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_score", int'(score), 0);
      chk("reset_mult", int'(mult), 1);
      chk("reset_go", int'(game_over), 0);

      // New game then a streak: 01,02,03,04 (mult 2), 06.
      step(0, 3'b000, 0, 0);
      step(0, 3'b010, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 3'b010, 1, 0);

      // Re-enter PLAY from IDLE, build 10 at mult 2, then simultaneous hit+miss.
      step(0, 3'b000, 0, 0);
      step(0, 3'b010, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 3'b010, 1, 0);
      step(0, 3'b010, 1, 1);

      // Pause holds everything; resuming does not clear.
      for (int i = 0; i < 3; i++) step(0, 3'b010, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 3'b011, 1, i == 1);
      for (int i = 0; i < 2; i++) step(0, 3'b010, 1, 0);

      // Finish: single pulse, frozen score; then a fresh game clears.
      for (int i = 0; i < 3; i++) step(0, 3'b101, 1, 0);
      step(0, 3'b010, 1, 0);

      // Saturation at 99.
      for (int i = 0; i < 45; i++) step(0, 3'b010, 1, 0);
      step(0, 3'b010, 1, 1);
      step(0, 3'b010, 1, 0);

      // Async reset in the middle of a streak.
      for (int i = 0; i < 3; i++) step(0, 3'b010, 1, 0);
      async_reset();
      step(0, 3'b010, 1, 0);

      // Random play including unused mode codes and occasional async resets.
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] md;
         md = mode;
         if ($urandom_range(0, 15) == 0) md = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 499) == 0) async_reset();
         else step(0, md, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      end

      step(0, 3'b000, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
